// File: rtl/pool_13x13_feeder.sv
// Feeder for pool_13x13: assembles KERNEL*KERNEL pixels into the im window bus,
// runs the pool handshake and forwards one result per window. Optional watchdog: POOL_FEED_TIMEOUT_EN.
module pool_13x13_feeder #(
   parameter int KERNEL         = 13,
   parameter int DW             = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [15:0]                 win_count,
   input  logic [DW-1:0]               data_in,
   input  logic                        data_in_valid,
   output logic                        data_in_ready,
   output logic [KERNEL*KERNEL*DW-1:0] im,
   output logic                        pool_ready,
   input  logic                        pool_valid,
   input  logic [DW-1:0]               om,
   output logic [DW-1:0]               result_data,
   output logic                        result_valid,
   input  logic                        result_ready,
   output logic                        busy,
   output logic                        done,
   output logic                        timeout_err
);

   localparam int BEATS = KERNEL * KERNEL;
   localparam int IMW   = BEATS * DW;
   localparam int BW    = $clog2(BEATS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   logic [1:0]    state;
   logic [BW-1:0] beat_cnt;
   logic [15:0]   win_cnt;
   logic [15:0]   win_total;
   logic [15:0]   win_next;
   logic          beat_fire;

   assign data_in_ready = (state == ST_LOAD);
   assign busy          = (state != ST_IDLE);
   assign beat_fire     = data_in_valid & data_in_ready;
   assign win_next      = win_cnt + 16'd1;

`ifdef POOL_FEED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] wd_cnt;
`else
   assign timeout_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

   // Oldest pixel of a window ends up in the top slot of im after the final shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         im           <= '0;
         beat_cnt     <= '0;
         win_cnt      <= '0;
         win_total    <= '0;
         pool_ready   <= 1'b0;
         result_data  <= '0;
         result_valid <= 1'b0;
         done         <= 1'b0;
`ifdef POOL_FEED_TIMEOUT_EN
         wd_cnt       <= '0;
         timeout_err  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (win_count == 16'd0) begin
                     done <= 1'b1;
                  end else begin
                     win_total <= win_count;
                     win_cnt   <= '0;
                     beat_cnt  <= '0;
                     state     <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (beat_fire) begin
                  im <= {im[IMW-DW-1:0], data_in};
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt   <= '0;
                     pool_ready <= 1'b1;
                     state      <= ST_ISSUE;
`ifdef POOL_FEED_TIMEOUT_EN
                     wd_cnt     <= '0;
`endif
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (pool_valid) begin
                  result_data  <= om;
                  pool_ready   <= 1'b0;
                  result_valid <= 1'b1;
                  state        <= ST_OUT;
               end
`ifdef POOL_FEED_TIMEOUT_EN
               else if (wd_cnt == WD_LAST) begin
                  pool_ready  <= 1'b0;
                  timeout_err <= 1'b1;
                  done        <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            ST_OUT: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  win_cnt      <= win_next;
                  if (win_next == win_total) begin
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     beat_cnt <= '0;
                     state    <= ST_LOAD;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
